// File: rtl/bmp_pkg.sv
// Shared definitions for the BMP master-port receive path: valid codes,
// serializer state encoding, buffer entry layout and frame counter helpers.
package bmp_pkg;

    localparam logic [1:0] VLD_IDLE = 2'b00;
    localparam logic [1:0] VLD_SLV0 = 2'b01;
    localparam logic [1:0] VLD_SLV1 = 2'b10;
    localparam logic [1:0] VLD_RSVD = 2'b11;

    localparam int FRAME_CNT_W = 16;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

    typedef struct packed {
        logic [31:0] word;
        logic        src;
        logic        last;
    } rx_entry_t;

    function automatic logic [FRAME_CNT_W-1:0] sat_inc(input logic [FRAME_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bmp_rx_buf.sv
// Circular word buffer with synchronous push/pop and a registered occupancy count.
module bmp_rx_buf #(
    parameter int DW    = 34,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][DW-1:0] mem;
    logic [AW-1:0]            wptr, rptr;
    logic [AW:0]              count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/bmp_master_rx.sv
// BMP master-port receiver: buffers tagged words and serializes them LSB-byte first.
// Optional frame byte checksum on frame_sum when BMP_RX_CHECKSUM_EN is defined.
module bmp_master_rx
    import bmp_pkg::*;
#(
    parameter int DATA_BUS_SIZE = 32,
    parameter int BUF_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_BUS_SIZE-1:0] data_to_master,
    input  logic [1:0]               mstr0_data_valid,
    input  logic                     mstr0_cmplt,
    output logic                     mstr0_ready,
    output logic [7:0]               out_byte,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_src,
    output logic                     out_last,
    output logic                     frame_done,
    output logic                     frame_src,
    output logic [FRAME_CNT_W-1:0]   frame_words,
    output logic [15:0]              frame_sum,
    output logic                     err
);
    rx_state_t state, nstate;

    logic        acc, rsvd, wr, in_src, mismatch, err_d;
    logic        in_first, in_fsrc;
    logic        full, empty, push, pop, byp, load, hs, word_end, fend;
    rx_entry_t   wentry, head, ld;
    logic [1:0]  idx, nxt_idx;
    logic [31:0] shreg;
    logic        cur_last, out_first, fsrc_out;
    logic [FRAME_CNT_W-1:0] words_cnt;

    // Input side: accept, classify, and per-frame source tracking.
    assign acc      = (mstr0_data_valid != VLD_IDLE) && mstr0_ready;
    assign rsvd     = (mstr0_data_valid == VLD_RSVD);
    assign wr       = acc && !rsvd;
    assign in_src   = (mstr0_data_valid == VLD_SLV1);
    assign mismatch = wr && !in_first && (in_src != in_fsrc);
    assign err_d    = (acc && rsvd) || (mstr0_cmplt && !acc) || mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_first <= 1'b1;
            in_fsrc  <= 1'b0;
        end else if (wr) begin
            if (in_first) in_fsrc <= in_src;
            in_first <= mstr0_cmplt;
        end
    end

    assign wentry = '{word: data_to_master, src: in_src, last: mstr0_cmplt};
    assign push   = wr && !byp;

    bmp_rx_buf #(.DW(DATA_BUS_SIZE + 2), .DEPTH(BUF_DEPTH)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign mstr0_ready = !full;

    // Serializer FSM; an idle serializer takes a word straight off the bus
    // when the buffer is empty so byte 0 appears the cycle after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RX_IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate   = state;
        pop      = 1'b0;
        byp      = 1'b0;
        word_end = (state == RX_SHIFT) && out_rdy && (idx == 2'd3);
        case (state)
            RX_IDLE: begin
                if (!empty) begin
                    pop    = 1'b1;
                    nstate = RX_SHIFT;
                end else if (wr) begin
                    byp    = 1'b1;
                    nstate = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (word_end) begin
                    if (!empty) pop    = 1'b1;
                    else        nstate = RX_IDLE;
                end
            end
        endcase
    end

    assign hs      = (state == RX_SHIFT) && out_rdy;
    assign load    = pop || byp;
    assign ld      = pop ? head : wentry;
    assign nxt_idx = idx + 2'd1;
    assign fend    = word_end && cur_last;
    assign out_vld = (state == RX_SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            idx      <= '0;
            cur_last <= 1'b0;
            out_byte <= '0;
            out_src  <= 1'b0;
            out_last <= 1'b0;
        end else if (load) begin
            shreg    <= ld.word;
            idx      <= 2'd0;
            cur_last <= ld.last;
            out_byte <= ld.word[7:0];
            out_src  <= ld.src;
            out_last <= 1'b0;
        end else if (hs) begin
            idx      <= nxt_idx;
            out_byte <= shreg[{nxt_idx, 3'b000} +: 8];
            out_last <= (nxt_idx == 2'd3) && cur_last;
        end
    end

    // Output-side frame accounting: word count, frame source, completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_cnt   <= '0;
            frame_words <= '0;
            frame_src   <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            out_first   <= 1'b1;
            fsrc_out    <= 1'b0;
        end else begin
            frame_done <= fend;
            err        <= err_d;
            if (load && (out_first || fend)) fsrc_out <= ld.src;
            if (load)      out_first <= 1'b0;
            else if (fend) out_first <= 1'b1;
            if (word_end) begin
                if (cur_last) begin
                    words_cnt   <= '0;
                    frame_words <= sat_inc(words_cnt);
                    frame_src   <= fsrc_out;
                end else begin
                    words_cnt   <= sat_inc(words_cnt);
                end
            end
        end
    end

`ifdef BMP_RX_CHECKSUM_EN
    logic [15:0] sum_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_acc   <= '0;
            frame_sum <= '0;
        end else if (hs) begin
            if (fend) begin
                frame_sum <= sum_acc + {8'd0, out_byte};
                sum_acc   <= '0;
            end else begin
                sum_acc   <= sum_acc + {8'd0, out_byte};
            end
        end
    end
`else
    assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_bmp_master_rx.sv
// Directed bench for bmp_master_rx: queue-based byte/frame model plus literal expectations.
module tb_bmp_master_rx;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_to_master;
    logic [1:0]  vld;
    logic        cmplt;
    logic        mstr0_ready;
    logic [7:0]  out_byte;
    logic        out_vld;
    logic        out_rdy;
    logic        out_src;
    logic        out_last;
    logic        frame_done;
    logic        frame_src;
    logic [15:0] frame_words;
    logic [15:0] frame_sum;
    logic        err;

    bmp_master_rx #(.DATA_BUS_SIZE(32), .BUF_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .data_to_master(data_to_master),
        .mstr0_data_valid(vld), .mstr0_cmplt(cmplt), .mstr0_ready(mstr0_ready),
        .out_byte(out_byte), .out_vld(out_vld), .out_rdy(out_rdy), .out_src(out_src),
        .out_last(out_last), .frame_done(frame_done), .frame_src(frame_src),
        .frame_words(frame_words), .frame_sum(frame_sum), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int err_seen = 0;
    int last_acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] b; logic src; logic last; } exp_byte_t;
    typedef struct { int words; logic src; logic [15:0] sum; } exp_frame_t;
    typedef struct { int cyc; logic [7:0] b; } byte_rec_t;
    typedef struct { int cyc; int words; logic src; logic [15:0] sum; } done_rec_t;

    exp_byte_t  exp_bytes[$];
    exp_frame_t exp_frames[$];
    byte_rec_t  blog[$];
    done_rec_t  dlog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic note_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Reference model: expected bytes and frame reports derived from accepted words.
    int          m_words;
    logic        m_src, m_first;
    logic [15:0] m_sum;
    logic        err_exp, done_exp;
    exp_frame_t  done_rec;
    logic        prev_hold, prev_src, prev_last;
    logic [7:0]  prev_byte;

    always @(negedge clk) begin
        logic acc, err_n, done_n, s;
        exp_byte_t e;
        exp_frame_t f;
        logic [31:0] w;
        if (rst) begin
            exp_bytes.delete();
            exp_frames.delete();
            m_words = 0; m_sum = 0; m_first = 1'b1; m_src = 1'b0;
            err_exp = 1'b0; done_exp = 1'b0; prev_hold = 1'b0;
        end else begin
            chk("err", err, err_exp);
            chk("frame_done", frame_done, done_exp);
            if (err) err_seen++;
            if (frame_done) dlog.push_back('{cyc, int'(frame_words), frame_src, frame_sum});
            if (done_exp) begin
                chk("frame_words", frame_words, done_rec.words);
                chk("frame_src", frame_src, done_rec.src);
                chk("frame_sum", frame_sum, done_rec.sum);
            end
            if (prev_hold) begin
                chk("hold_vld", out_vld, 1'b1);
                chk("hold_byte", out_byte, prev_byte);
                chk("hold_src", out_src, prev_src);
                chk("hold_last", out_last, prev_last);
            end
            done_n = 1'b0;
            if (out_vld && out_rdy) begin
                blog.push_back('{cyc, out_byte});
                if (exp_bytes.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_byte_unexpected actual=%h required=none", out_byte);
                end else begin
                    e = exp_bytes.pop_front();
                    chk("out_byte", out_byte, e.b);
                    chk("out_src", out_src, e.src);
                    chk("out_last", out_last, e.last);
                    if (e.last && exp_frames.size() > 0) begin
                        done_rec = exp_frames.pop_front();
                        done_n = 1'b1;
                    end
                end
            end
            prev_hold = out_vld && !out_rdy;
            prev_byte = out_byte; prev_src = out_src; prev_last = out_last;

            acc   = (vld != 2'b00) && mstr0_ready;
            err_n = (acc && vld == 2'b11) || (cmplt && !acc);
            if (acc && vld != 2'b11) begin
                s = (vld == 2'b10);
                if (!m_first && s != m_src) err_n = 1'b1;
                if (m_first) m_src = s;
                m_first = 1'b0;
                w = data_to_master;
                for (int j = 0; j < 4; j++) begin
                    exp_bytes.push_back('{w[8*j +: 8], s, (j == 3) && cmplt});
`ifdef BMP_RX_CHECKSUM_EN
                    m_sum = m_sum + {8'd0, w[8*j +: 8]};
`endif
                end
                m_words++;
                if (cmplt) begin
                    f = '{m_words, m_src, m_sum};
                    exp_frames.push_back(f);
                    m_words = 0; m_sum = 0; m_first = 1'b1;
                end
            end
            err_exp  = err_n;
            done_exp = done_n;
        end
    end

    task automatic send(input logic [31:0] w, input logic [1:0] v, input logic c);
        int n;
        data_to_master = w; vld = v; cmplt = c; n = 0;
        @(negedge clk);
        while (!mstr0_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!mstr0_ready) note_timeout("send_accept");
        last_acc_cyc = cyc;
        @(posedge clk);
        #1;
        vld = 2'b00; cmplt = 1'b0; data_to_master = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, mstr0_ready, 1'b1);
        chk({tag, "_out_vld"}, out_vld, 1'b0);
        chk({tag, "_out_byte"}, out_byte, 8'h00);
        chk({tag, "_out_src"}, out_src, 1'b0);
        chk({tag, "_out_last"}, out_last, 1'b0);
        chk({tag, "_frame_done"}, frame_done, 1'b0);
        chk({tag, "_frame_words"}, frame_words, 16'h0);
        chk({tag, "_frame_src"}, frame_src, 1'b0);
        chk({tag, "_frame_sum"}, frame_sum, 16'h0);
        chk({tag, "_err"}, err, 1'b0);
    endtask

    logic [31:0] bp_w[6];
    logic [31:0] tmp;
    int b0, d0, e0, n, nacc;

    initial begin
        rst = 1'b1; data_to_master = '0; vld = 2'b00; cmplt = 1'b0; out_rdy = 1'b1;
        #2;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single-word frame: bytes on N+1..N+4, frame_done at N+5.
        b0 = blog.size(); d0 = dlog.size();
        send(32'h44332211, 2'b01, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        chk("t1_nbytes", blog.size() - b0, 4);
        if (blog.size() - b0 == 4) begin
            tmp = 32'h44332211;
            for (int k = 0; k < 4; k++) begin
                chk("t1_byte", blog[b0+k].b, tmp[8*k +: 8]);
                chk("t1_byte_cyc", blog[b0+k].cyc - last_acc_cyc, k + 1);
            end
        end
        chk("t1_ndone", dlog.size() - d0, 1);
        if (dlog.size() - d0 == 1) begin
            chk("t1_done_cyc", dlog[d0].cyc - last_acc_cyc, 5);
            chk("t1_words", dlog[d0].words, 1);
            chk("t1_src", dlog[d0].src, 1'b0);
`ifdef BMP_RX_CHECKSUM_EN
            chk("t1_sum", dlog[d0].sum, 16'h00AA);
`else
            chk("t1_sum", dlog[d0].sum, 16'h0000);
`endif
        end

        // Backpressure: one word held in the serializer plus four buffered.
        b0 = blog.size(); d0 = dlog.size();
        for (int k = 0; k < 6; k++) bp_w[k] = 32'h10203040 + k * 32'h01010101;
        out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) send(bp_w[k], 2'b01, 1'b0);
        @(negedge clk);
        chk("t2_ready_low", mstr0_ready, 1'b0);
        data_to_master = bp_w[5]; vld = 2'b01; cmplt = 1'b1;
        repeat (3) @(negedge clk);
        chk("t2_ready_still_low", mstr0_ready, 1'b0);
        chk("t2_no_bytes", blog.size() - b0, 0);
        @(posedge clk);
        #1 out_rdy = 1'b1;
        n = 0;
        @(negedge clk);
        while (!mstr0_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!mstr0_ready) note_timeout("t2_space");
        @(posedge clk);
        #1 vld = 2'b00; cmplt = 1'b0; data_to_master = '0;
        repeat (30) @(posedge clk);
        #1;
        chk("t2_nbytes", blog.size() - b0, 24);
        if (blog.size() - b0 == 24) begin
            for (int k = 0; k < 6; k++) begin
                tmp = bp_w[k];
                for (int j = 0; j < 4; j++) chk("t2_order", blog[b0+4*k+j].b, tmp[8*j +: 8]);
            end
        end
        chk("t2_ndone", dlog.size() - d0, 1);
        if (dlog.size() - d0 == 1) chk("t2_words", dlog[d0].words, 6);

        // Reserved code and stray cmplt: one err pulse each, nothing emitted.
        b0 = blog.size(); d0 = dlog.size(); e0 = err_seen;
        send(32'hDEADBEEF, 2'b11, 1'b0);
        repeat (3) @(posedge clk);
        #1 cmplt = 1'b1;
        @(posedge clk);
        #1 cmplt = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t3_err_pulses", err_seen - e0, 2);
        chk("t3_no_bytes", blog.size() - b0, 0);
        chk("t3_no_done", dlog.size() - d0, 0);

        // Back-to-back frames: A = 3 words slave 1, B = 2 words slave 0.
        b0 = blog.size(); d0 = dlog.size();
        send(32'hA1A2A3A4, 2'b10, 1'b0);
        send(32'hB1B2B3B4, 2'b10, 1'b0);
        send(32'hC1C2C3C4, 2'b10, 1'b1);
        send(32'h01020304, 2'b01, 1'b0);
        send(32'h05060708, 2'b01, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        chk("t4_nbytes", blog.size() - b0, 20);
        if (blog.size() - b0 == 20) begin
            nacc = 0;
            for (int k = 1; k < 20; k++) if (blog[b0+k].cyc - blog[b0+k-1].cyc != 1) nacc++;
            chk("t4_bubbles", nacc, 0);
        end
        chk("t4_ndone", dlog.size() - d0, 2);
        if (dlog.size() - d0 == 2) begin
            chk("t4_a_words", dlog[d0].words, 3);
            chk("t4_a_src", dlog[d0].src, 1'b1);
            chk("t4_b_words", dlog[d0+1].words, 2);
            chk("t4_b_src", dlog[d0+1].src, 1'b0);
        end

        // Source mismatch inside a frame: err, word still forwarded.
        b0 = blog.size(); d0 = dlog.size(); e0 = err_seen;
        send(32'h11111111, 2'b01, 1'b0);
        send(32'h22222222, 2'b10, 1'b1);
        repeat (14) @(posedge clk);
        #1;
        chk("t5_err_pulses", err_seen - e0, 1);
        chk("t5_nbytes", blog.size() - b0, 8);
        chk("t5_ndone", dlog.size() - d0, 1);
        if (dlog.size() - d0 == 1) begin
            chk("t5_words", dlog[d0].words, 2);
            chk("t5_src", dlog[d0].src, 1'b0);
        end

        // Reset after two bytes of a two-word frame.
        b0 = blog.size(); d0 = dlog.size();
        send(32'h55667788, 2'b01, 1'b0);
        send(32'h99AABBCC, 2'b01, 1'b1);
        n = 0;
        @(negedge clk);
        #1;
        while (blog.size() - b0 < 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (blog.size() - b0 < 2) note_timeout("t6_two_bytes");
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_done", dlog.size() - d0, 0);
        send(32'h0BADF00D, 2'b10, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        chk("t6_ndone", dlog.size() - d0, 1);
        if (dlog.size() - d0 == 1) begin
            chk("t6_words", dlog[d0].words, 1);
            chk("t6_src", dlog[d0].src, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
